// File: rtl/bp_update_scheduler_pkg.sv
// Shared types and constants for the branch-predictor update scheduler.
// The queue entry is the {pc, taken} pair that the predictor trains on.
package bp_update_scheduler_pkg;

    localparam int BP_Q_DEPTH_WIDTH = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } bp_update_t;

endpackage

// File: rtl/bp_outcome_fifo.sv
// Two-write / one-read circular queue of resolved branch outcomes.
// Lane 0 is older: when both lanes write, lane 0 lands at tail and lane 1 at tail+1.
module bp_outcome_fifo
    import bp_update_scheduler_pkg::*;
#(
    parameter int DEPTH_WIDTH = BP_Q_DEPTH_WIDTH
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 en,
    input  logic                 wr0_en,
    input  bp_update_t           wr0_data,
    input  logic                 wr1_en,
    input  bp_update_t           wr1_data,
    input  logic                 rd_en,
    output bp_update_t           rd_data,
    output logic [DEPTH_WIDTH:0] count
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;

    bp_update_t             mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] head;
    logic [DEPTH_WIDTH-1:0] tail;
    logic [DEPTH_WIDTH-1:0] tail_p1;
    logic                   first_en;
    logic                   second_en;
    bp_update_t             first_data;
    logic [1:0]             n_push;

    // A lone lane-1 write takes the tail slot so no bubble is left behind.
    assign first_en   = wr0_en | wr1_en;
    assign second_en  = wr0_en & wr1_en;
    assign first_data = wr0_en ? wr0_data : wr1_data;
    assign n_push     = {1'b0, wr0_en} + {1'b0, wr1_en};
    assign tail_p1    = tail + 1'b1;
    assign rd_data    = mem[head];

    always_ff @(posedge clk_in) begin
        if (!rst_in && en) begin
            if (first_en)  mem[tail]    <= first_data;
            if (second_en) mem[tail_p1] <= wr1_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (en) begin
            tail  <= tail + DEPTH_WIDTH'(n_push);
            if (rd_en) head <= head + 1'b1;
            count <= count + (DEPTH_WIDTH+1)'(n_push) - (DEPTH_WIDTH+1)'(rd_en);
        end
    end

endmodule

// File: rtl/bp_update_scheduler.sv
// Buffers up to two committed branch outcomes per cycle and drains them one per
// cycle into the predictor update port; also keeps saturating perf counters.
module bp_update_scheduler
    import bp_update_scheduler_pkg::*;
#(
    parameter int DEPTH_WIDTH = BP_Q_DEPTH_WIDTH,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 c0_valid,
    input  logic [31:0]          c0_pc,
    input  logic                 c0_taken,
    input  logic                 c0_pred,
    input  logic                 c1_valid,
    input  logic [31:0]          c1_pc,
    input  logic                 c1_taken,
    input  logic                 c1_pred,
    output logic                 commit_ready,
    output logic                 update_control,
    output logic [31:0]          update_pc,
    output logic                 update_jump,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] mispred_cnt
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;

    logic [DEPTH_WIDTH:0] count;
    logic                 acc0;
    logic                 acc1;
    logic                 pop;
    bp_update_t           head_entry;
    logic [1:0]           n_br;
    logic [1:0]           n_mis;
    logic [CNT_WIDTH:0]   br_sum;
    logic [CNT_WIDTH:0]   mis_sum;

    // Deliberately ignores a same-cycle pop so commit_ready stays off the pop path.
    assign commit_ready = (count <= (DEPTH_WIDTH+1)'(DEPTH - 2));
    assign acc0         = rdy_in & commit_ready & c0_valid;
    assign acc1         = rdy_in & commit_ready & c1_valid;
    assign pop          = rdy_in & (count != '0);

    bp_outcome_fifo #(.DEPTH_WIDTH(DEPTH_WIDTH)) u_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .en       (rdy_in),
        .wr0_en   (acc0),
        .wr0_data ('{pc: c0_pc, taken: c0_taken}),
        .wr1_en   (acc1),
        .wr1_data ('{pc: c1_pc, taken: c1_taken}),
        .rd_en    (pop),
        .rd_data  (head_entry),
        .count    (count)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            update_control <= 1'b0;
            update_pc      <= '0;
            update_jump    <= 1'b0;
        end else begin
            // Strobe drops while stalled so one entry never trains twice.
            update_control <= pop;
            if (pop) begin
                update_pc   <= head_entry.pc;
                update_jump <= head_entry.taken;
            end
        end
    end

    assign n_br    = {1'b0, acc0} + {1'b0, acc1};
    assign n_mis   = {1'b0, acc0 & (c0_pred != c0_taken)} + {1'b0, acc1 & (c1_pred != c1_taken)};
    assign br_sum  = {1'b0, branch_cnt}  + (CNT_WIDTH+1)'(n_br);
    assign mis_sum = {1'b0, mispred_cnt} + (CNT_WIDTH+1)'(n_mis);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            branch_cnt  <= br_sum[CNT_WIDTH]  ? '1 : br_sum[CNT_WIDTH-1:0];
            mispred_cnt <= mis_sum[CNT_WIDTH] ? '1 : mis_sum[CNT_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Scoreboard bench: accepted commits are queued as expected updates and popped
// when the update strobe fires; a narrow-counter instance covers saturation.
module tb_bp_update_scheduler;
    import bp_update_scheduler_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        c0_valid, c0_taken, c0_pred, c1_valid, c1_taken, c1_pred;
    logic [31:0] c0_pc, c1_pc;
    logic        commit_ready, update_control, update_jump;
    logic [31:0] update_pc, branch_cnt, mispred_cnt;
    logic        s_ready, s_ctrl, s_jump;
    logic [31:0] s_pc;
    logic [3:0]  s_branch, s_mis;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_in = ~clk_in;

    bp_update_scheduler dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .c0_valid(c0_valid), .c0_pc(c0_pc), .c0_taken(c0_taken), .c0_pred(c0_pred),
        .c1_valid(c1_valid), .c1_pc(c1_pc), .c1_taken(c1_taken), .c1_pred(c1_pred),
        .commit_ready(commit_ready), .update_control(update_control),
        .update_pc(update_pc), .update_jump(update_jump),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    bp_update_scheduler #(.CNT_WIDTH(4)) dut_s (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .c0_valid(c0_valid), .c0_pc(c0_pc), .c0_taken(c0_taken), .c0_pred(c0_pred),
        .c1_valid(c1_valid), .c1_pc(c1_pc), .c1_taken(c1_taken), .c1_pred(c1_pred),
        .commit_ready(s_ready), .update_control(s_ctrl),
        .update_pc(s_pc), .update_jump(s_jump),
        .branch_cnt(s_branch), .mispred_cnt(s_mis)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, evaluated on inputs that are stable across the edge.
    bp_update_t  exp_q[$];
    bit          mon_en = 0;
    bit          m_fire = 0;
    logic [31:0] m_last_pc = '0;
    logic        m_last_j  = 1'b0;
    longint      m_br = 0, m_mis = 0, m_br_s = 0, m_mis_s = 0;

    function automatic longint sat(input longint v, input longint max);
        return (v > max) ? max : v;
    endfunction

    always @(posedge clk_in) begin
        if (rst_in) begin
            exp_q.delete();
            mon_en = 1; m_fire = 0; m_last_pc = '0; m_last_j = 0;
            m_br = 0; m_mis = 0; m_br_s = 0; m_mis_s = 0;
        end else if (!rdy_in) begin
            m_fire = 0;
        end else begin
            bit cr, a0, a1;
            int nb, nm;
            m_fire = (exp_q.size() != 0);
            cr = (exp_q.size() <= 6);
            a0 = c0_valid && cr;
            a1 = c1_valid && cr;
            if (a0) exp_q.push_back('{pc: c0_pc, taken: c0_taken});
            if (a1) exp_q.push_back('{pc: c1_pc, taken: c1_taken});
            nb = int'(a0) + int'(a1);
            nm = int'(a0 && (c0_pred != c0_taken)) + int'(a1 && (c1_pred != c1_taken));
            m_br    = sat(m_br + nb, 64'hFFFF_FFFF);
            m_mis   = sat(m_mis + nm, 64'hFFFF_FFFF);
            m_br_s  = sat(m_br_s + nb, 15);
            m_mis_s = sat(m_mis_s + nm, 15);
        end
    end

    always @(negedge clk_in) begin
        if (mon_en) begin
            if (m_fire) begin
                if (exp_q.size() == 0) chk("spurious_pop", 1, 0);
                else begin
                    bp_update_t e;
                    e = exp_q.pop_front();
                    m_last_pc = e.pc;
                    m_last_j  = e.taken;
                end
            end
            chk("update_control", update_control, m_fire);
            chk("update_pc",      update_pc,      m_last_pc);
            chk("update_jump",    update_jump,    m_last_j);
            chk("commit_ready",   commit_ready,   exp_q.size() <= 6);
            chk("branch_cnt",     branch_cnt,     m_br);
            chk("mispred_cnt",    mispred_cnt,    m_mis);
            chk("s_ctrl",         s_ctrl,         m_fire);
            chk("s_pc",           s_pc,           m_last_pc);
            chk("s_branch_sat",   s_branch,       m_br_s);
            chk("s_mispred_sat",  s_mis,          m_mis_s);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic lanes(input logic v0, input logic [31:0] p0, input logic t0, input logic pr0,
                         input logic v1, input logic [31:0] p1, input logic t1, input logic pr1);
        c0_valid = v0; c0_pc = p0; c0_taken = t0; c0_pred = pr0;
        c1_valid = v1; c1_pc = p1; c1_taken = t1; c1_pred = pr1;
    endtask

    task automatic idle(input int n);
        lanes(0, 0, 0, 0, 0, 0, 0, 0);
        tick(n);
    endtask

    initial begin
        rst_in = 1; rdy_in = 1;
        lanes(0, 0, 0, 0, 0, 0, 0, 0);
        tick(2);
        rst_in = 0;
        idle(2);

        // single push, two-edge latency to the update port
        lanes(1, 32'h1000, 1, 0, 0, 0, 0, 0);
        tick(1);
        idle(4);

        // dual pushes until the queue fills; extra pairs must be dropped
        for (int i = 0; i < 8; i++) begin
            lanes(1, 32'h2000, 1, 1, 1, 32'h2004, 0, 1);
            tick(1);
        end
        idle(12);

        // lane-1-only and lane-0-only single-slot pushes
        lanes(0, 32'hDEAD, 1, 1, 1, 32'h3004, 0, 1);
        tick(1);
        lanes(1, 32'h3008, 1, 1, 0, 0, 0, 0);
        tick(1);
        idle(4);

        // stall while the strobe is high and entries remain
        lanes(1, 32'h4000, 0, 0, 1, 32'h4004, 1, 1);
        tick(1);
        lanes(1, 32'h4008, 1, 0, 1, 32'h400C, 0, 0);
        tick(1);
        idle(0);
        rdy_in = 0;
        lanes(1, 32'hBAD0, 1, 0, 1, 32'hBAD4, 1, 0);
        tick(3);
        rdy_in = 1;
        idle(8);

        // random traffic with occasional stalls
        for (int i = 0; i < 80; i++) begin
            rdy_in = ($urandom_range(0, 5) != 0);
            lanes($urandom_range(0, 1), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1), $urandom_range(0, 1));
            tick(1);
        end
        rdy_in = 1;
        idle(12);

        // reset while entries are queued and rdy_in is low
        for (int i = 0; i < 3; i++) begin
            lanes(1, 32'h5000, 1, 0, 1, 32'h5004, 1, 0);
            tick(1);
        end
        lanes(0, 0, 0, 0, 0, 0, 0, 0);
        rdy_in = 0; rst_in = 1;
        tick(1);
        rst_in = 0;
        tick(1);
        rdy_in = 1;
        idle(6);

        chk("drain_left", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
